// File: rtl/cpu_pkg.sv
// Shared CPU types: B.cond condition codes and the NZCV flag struct.
package cpu_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, HS = 4'h2, LO = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    localparam nzcv_t NZCV_RESET = 4'b0000;

endpackage

// File: rtl/alu_flag_unit_if.sv
// EX/ID-side signal bundle of the flag unit. The pipeline drives (master), the
// flag unit consumes and reports back (slave). Every output is a plain level,
// there is no valid/ready handshake: br_valid_q is a one-cycle pulse.
interface alu_flag_unit_if #(parameter int WIDTH = 64);
    import cpu_pkg::*;

    logic             ex_valid;
    logic             ex_set_flags;
    logic             ex_stall;
    logic             ex_flush;
    logic [WIDTH-1:0] alu_result;
    logic             alu_negative;
    logic             alu_zero;
    logic             alu_overflow;
    logic             alu_carry_out;
    logic             id_br_cond;
    logic [3:0]       id_cond;
    logic             id_stall;
    nzcv_t            flags_q;
    logic             flag_hazard;
    logic             br_valid_q;
    logic             br_taken_q;

    modport master (
        output ex_valid, ex_set_flags, ex_stall, ex_flush, alu_result,
               alu_negative, alu_zero, alu_overflow, alu_carry_out,
               id_br_cond, id_cond, id_stall,
        input  flags_q, flag_hazard, br_valid_q, br_taken_q
    );

    modport slave (
        input  ex_valid, ex_set_flags, ex_stall, ex_flush, alu_result,
               alu_negative, alu_zero, alu_overflow, alu_carry_out,
               id_br_cond, id_cond, id_stall,
        output flags_q, flag_hazard, br_valid_q, br_taken_q
    );

endinterface

// File: rtl/alu_flag_unit_cond_eval.sv
// Combinational evaluation of a 4-bit condition code against NZCV flags.
module cond_eval
    import cpu_pkg::*;
(
    input  nzcv_t flags,
    input  cond_e cond,
    output logic  cond_true
);

    always_comb begin
        cond_true = 1'b1;
        case (cond)
            EQ: cond_true = flags.z;
            NE: cond_true = !flags.z;
            HS: cond_true = flags.c;
            LO: cond_true = !flags.c;
            MI: cond_true = flags.n;
            PL: cond_true = !flags.n;
            VS: cond_true = flags.v;
            VC: cond_true = !flags.v;
            HI: cond_true = flags.c && !flags.z;
            LS: cond_true = !(flags.c && !flags.z);
            GE: cond_true = (flags.n == flags.v);
            LT: cond_true = (flags.n != flags.v);
            GT: cond_true = !flags.z && (flags.n == flags.v);
            LE: cond_true = !(!flags.z && (flags.n == flags.v));
            default: cond_true = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_flag_unit.sv
// EX-stage NZCV register and B.cond resolver. Define FLAG_BYPASS_EN to forward
// live ALU flags to ID; otherwise ID is stalled one cycle behind a flag setter.
module alu_flag_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input logic            clk,
    input logic            reset,
    alu_flag_unit_if.slave bus
);

    nzcv_t alu_flags;
    nzcv_t eff;
    nzcv_t flags_r;
    logic  live;
    logic  commit;
    logic  resolve;
    logic  cond_true;
    logic  br_valid_r;
    logic  br_taken_r;

    assign alu_flags = {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow};
    // A stalled setter is still "live": its flags are final even though it has not committed.
    assign live      = bus.ex_valid & bus.ex_set_flags & ~bus.ex_flush;
    assign commit    = live & ~bus.ex_stall;

`ifdef FLAG_BYPASS_EN
    assign eff             = live ? alu_flags : flags_r;
    assign bus.flag_hazard = 1'b0;
`else
    assign eff             = flags_r;
    assign bus.flag_hazard = bus.id_br_cond & live;
`endif

    assign resolve = bus.id_br_cond & ~bus.id_stall & ~bus.flag_hazard;

    cond_eval u_cond_eval (
        .flags     (eff),
        .cond      (cond_e'(bus.id_cond)),
        .cond_true (cond_true)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r    <= NZCV_RESET;
            br_valid_r <= 1'b0;
            br_taken_r <= 1'b0;
        end else begin
            if (commit) begin
                flags_r <= alu_flags;
            end
            br_valid_r <= resolve;
            br_taken_r <= resolve & cond_true;
        end
    end

    assign bus.flags_q    = flags_r;
    assign bus.br_valid_q = br_valid_r;
    assign bus.br_taken_q = br_taken_r;

    // The ALU zero flag must agree with the result it describes whenever it is committed.
    zero_flag_consistent: assert property (@(posedge clk) disable iff (reset)
        commit |-> (bus.alu_zero == (bus.alu_result == {WIDTH{1'b0}})));

endmodule

// File: tb/tb_alu_flag_unit.sv
// Bench for alu_flag_unit: directed scenarios plus random traffic, checked
// against an architectural flag model through an expected-branch queue.
module tb_alu_flag_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_flag_unit_if #(.WIDTH(64)) bus ();

    alu_flag_unit #(.WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [3:0] model_flags = 4'b0000;
    logic [0:0] exp_q[$];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ARM-style encoding: bits [3:1] select a base test, bit 0 inverts it (except 1111).
    function automatic logic cond_holds(input logic [3:0] f, input logic [3:0] cc);
        logic n, z, c, v, r;
        {n, z, c, v} = f;
        case (cc[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (cc[0] && cc != 4'hF) r = !r;
        return r;
    endfunction

    task automatic drive(input logic v, input logic sf, input logic st, input logic fl,
                         input logic [3:0] nzcv, input logic bc, input logic [3:0] cc,
                         input logic idst);
        logic       live, hz, res;
        logic [3:0] eff;
        @(negedge clk);
        bus.ex_valid      = v;
        bus.ex_set_flags  = sf;
        bus.ex_stall      = st;
        bus.ex_flush      = fl;
        bus.alu_negative  = nzcv[3];
        bus.alu_zero      = nzcv[2];
        bus.alu_carry_out = nzcv[1];
        bus.alu_overflow  = nzcv[0];
        bus.alu_result    = nzcv[2] ? 64'd0 : ({32'($urandom), 32'($urandom)} | 64'd1);
        bus.id_br_cond    = bc;
        bus.id_cond       = cc;
        bus.id_stall      = idst;
        #1;
        live = v && sf && !fl;
`ifdef FLAG_BYPASS_EN
        hz  = 1'b0;
        eff = live ? nzcv : model_flags;
`else
        hz  = bc && live;
        eff = model_flags;
`endif
        check("flag_hazard", {3'b0, bus.flag_hazard}, {3'b0, hz});
        res = bc && !idst && !hz;
        if (res) exp_q.push_back(cond_holds(eff, cc));
        if (live && !st) model_flags = nzcv;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.ex_valid   = 1'b0;
        bus.id_br_cond = 1'b0;
        #3 reset = 1'b1;
        exp_q.delete();
        model_flags = 4'b0000;
        #1;
        check("reset_flags", bus.flags_q, 4'b0000);
        check("reset_br_valid", {3'b0, bus.br_valid_q}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: flags every cycle, branch outcome whenever a pulse is presented.
    initial begin
        logic [0:0] e;
        forever begin
            @(posedge clk);
            #1;
            check("flags_q", bus.flags_q, model_flags);
            if (bus.br_valid_q) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL br_unexpected: got br_valid_q=1 expected no pulse at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("br_taken", {3'b0, bus.br_taken_q}, {3'b0, e});
                end
            end else begin
                check("br_taken_idle", {3'b0, bus.br_taken_q}, 4'b0000);
            end
        end
    end

    initial begin
        reset             = 1'b1;
        bus.ex_valid      = 1'b0;
        bus.ex_set_flags  = 1'b0;
        bus.ex_stall      = 1'b0;
        bus.ex_flush      = 1'b0;
        bus.alu_result    = 64'd1;
        bus.alu_negative  = 1'b0;
        bus.alu_zero      = 1'b0;
        bus.alu_overflow  = 1'b0;
        bus.alu_carry_out = 1'b0;
        bus.id_br_cond    = 1'b0;
        bus.id_cond       = 4'h0;
        bus.id_stall      = 1'b0;
        #2;
        check("por_flags", bus.flags_q, 4'b0000);
        check("por_br_valid", {3'b0, bus.br_valid_q}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // EQ straight after reset: Z=0, not taken.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'h0, 1'b0);
        idle();

        // SUBS N=0 Z=1 C=1 V=0, then NE.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b0, 4'h0, 1'b0);
        @(posedge clk);
        #2 check("subs_flags", bus.flags_q, 4'b0110);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'h1, 1'b0);
        idle();

        // ADDS N=1 V=0 with B.cond LT in ID the same cycle, then re-presented.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, 4'hB, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'hB, 1'b0);
        idle();

        // Flush: clear flags, then a flushed Z=1 setter with a concurrent EQ.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 4'h0, 1'b0);
        @(posedge clk);
        #2 check("flush_flags", bus.flags_q, 4'b0000);
        idle();

        // Stalled setter for 3 cycles, then released.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b1011, 1'b0, 4'h0, 1'b0);
            @(posedge clk);
            #2 check("stall_hold", bus.flags_q, 4'b0000);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b1011, 1'b0, 4'h0, 1'b0);
        @(posedge clk);
        #2 check("stall_release", bus.flags_q, 4'b1011);

        // AL held in a stalled ID, then released.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'hE, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'hE, 1'b0);
        idle();

        // Random traffic with occasional asynchronous resets mid-stream.
        for (int i = 0; i < 2000; i++) begin
            if (i % 500 == 250) begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'hF, 1'b0);
                do_reset();
            end else begin
                drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                      $urandom_range(0, 9) < 2, $urandom_range(0, 19) < 3,
                      4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                      4'($urandom_range(0, 15)), $urandom_range(0, 4) == 0);
            end
        end
        idle();
        @(posedge clk);
        #3;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL exp_q_drained: got %0d pending branches expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
